// File: rtl/mux4_sync.sv
// 4:1 mux with a combinational output and a registered, valid-qualified copy.
// Define MUX4_SYNC_HOLD_EN to hold f_q/sel_q on cycles without in_valid.
module mux4_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q,
    output logic             f_q_valid,
    output logic [1:0]       sel_q
);

    always_comb begin
        f = a;
        unique case (sel)
            2'b00: f = a;
            2'b01: f = b;
            2'b10: f = c;
            2'b11: f = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q       <= '0;
            sel_q     <= 2'b00;
            f_q_valid <= 1'b0;
        end else begin
            f_q_valid <= in_valid;
`ifdef MUX4_SYNC_HOLD_EN
            if (in_valid) begin
                f_q   <= f;
                sel_q <= sel;
            end
`else
            f_q   <= f;
            sel_q <= sel;
`endif
        end
    end

endmodule

// File: tb/tb_mux4_sync.sv
// Bench for mux4_sync at WIDTH 1, 2, 8 and 64 against an array-lookup model.
// Directed cases pin the model; a random phase runs 1000 cycles.
module tb_mux4_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        in_valid;
    logic [63:0] a, b, c, d;
    logic        chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [0:0]  f1, fq1;
    logic [1:0]  f2, fq2;
    logic [7:0]  f8, fq8;
    logic [63:0] f64, fq64;
    logic [1:0]  sq1, sq2, sq8, sq64;
    logic        v1, v2, v8, v64;

    logic [63:0] m_fq;
    logic [1:0]  m_sel;
    logic        m_v;

    always #5 clk = ~clk;

    mux4_sync #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .sel(sel),
        .a(a[0:0]), .b(b[0:0]), .c(c[0:0]), .d(d[0:0]),
        .in_valid(in_valid), .f(f1), .f_q(fq1),
        .f_q_valid(v1), .sel_q(sq1)
    );
    mux4_sync #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .sel(sel),
        .a(a[1:0]), .b(b[1:0]), .c(c[1:0]), .d(d[1:0]),
        .in_valid(in_valid), .f(f2), .f_q(fq2),
        .f_q_valid(v2), .sel_q(sq2)
    );
    mux4_sync #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .sel(sel),
        .a(a[7:0]), .b(b[7:0]), .c(c[7:0]), .d(d[7:0]),
        .in_valid(in_valid), .f(f8), .f_q(fq8),
        .f_q_valid(v8), .sel_q(sq8)
    );
    mux4_sync #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .sel(sel),
        .a(a), .b(b), .c(c), .d(d),
        .in_valid(in_valid), .f(f64), .f_q(fq64),
        .f_q_valid(v64), .sel_q(sq64)
    );

    function automatic logic [63:0] pick(input logic [1:0] s);
        logic [63:0] arr [4];
        arr = '{a, b, c, d};
        return arr[s];
    endfunction

    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // Reference: registered stage in terms of the select rules.
    always @(posedge clk) begin
        if (rst) begin
            m_fq  <= '0;
            m_sel <= 2'b00;
            m_v   <= 1'b0;
        end else begin
            m_v <= in_valid;
`ifdef MUX4_SYNC_HOLD_EN
            if (in_valid) begin
                m_fq  <= pick(sel);
                m_sel <= sel;
            end
`else
            m_fq  <= pick(sel);
            m_sel <= sel;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("f_w1", 64'(f1), pick(sel) & msk(1));
            chk("f_w2", 64'(f2), pick(sel) & msk(2));
            chk("f_w8", 64'(f8), pick(sel) & msk(8));
            chk("f_w64", f64, pick(sel));
            chk("fq_w1", 64'(fq1), m_fq & msk(1));
            chk("fq_w2", 64'(fq2), m_fq & msk(2));
            chk("fq_w8", 64'(fq8), m_fq & msk(8));
            chk("fq_w64", fq64, m_fq);
            chk("selq_w1", 64'(sq1), 64'(m_sel));
            chk("selq_w64", 64'(sq64), 64'(m_sel));
            chk("v_w1", 64'(v1), 64'(m_v));
            chk("v_w2", 64'(v2), 64'(m_v));
            chk("v_w8", 64'(v8), 64'(m_v));
            chk("v_w64", 64'(v64), 64'(m_v));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; sel = 2'b00;
        a = '1; b = '1; c = '1; d = '1;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk_en = 1'b1;
        #3;
        chk("rst_fq", fq64, 64'd0);
        chk("rst_selq", 64'(sq8), 64'd0);
        chk("rst_v", 64'(v8), 64'd0);

        // same-cycle select sweep at WIDTH 2
        a = 64'd0; b = 64'd1; c = 64'd2; d = 64'd3;
        for (int s = 0; s < 4; s++) begin
            tick();
            sel = 2'(s);
            #3;
            chk("sweep_w2", 64'(f2), 64'(s));
        end

        // single valid capture at WIDTH 8
        tick();
        sel = 2'b10; c = 64'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #3;
        chk("cap_fq", 64'(fq8), 64'hA5);
        chk("cap_selq", 64'(sq8), 64'd2);
        chk("cap_v", 64'(v8), 64'd1);
        tick();
        #3;
        chk("idle_v", 64'(v8), 64'd0);

        // reset beats valid
        tick();
        rst = 1'b1; in_valid = 1'b1; sel = 2'b11; d = 64'hFF;
        #3;
        chk("rst_f_pre", 64'(f8), 64'hFF);
        tick();
        #3;
        chk("rstv_fq", 64'(fq8), 64'd0);
        chk("rstv_selq", 64'(sq8), 64'd0);
        chk("rstv_v", 64'(v8), 64'd0);
        chk("rst_f_post", 64'(f8), 64'hFF);

        // hold versus follow on an idle cycle
        tick();
        rst = 1'b0; sel = 2'b01; b = 64'h3C; in_valid = 1'b1;
        tick();
        sel = 2'b00; a = 64'h11; in_valid = 1'b0;
        tick();
        #3;
`ifdef MUX4_SYNC_HOLD_EN
        chk("hold_fq", 64'(fq8), 64'h3C);
        chk("hold_selq", 64'(sq8), 64'd1);
`else
        chk("follow_fq", 64'(fq8), 64'h11);
        chk("follow_selq", 64'(sq8), 64'd0);
`endif
        chk("idle2_v", 64'(v8), 64'd0);

        // random phase
        for (int i = 0; i < 1000; i++) begin
            tick();
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            d = {$urandom, $urandom};
            sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 49) == 0);
        end
        tick();
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_sync.md
MUX4_SYNC -- requirements
Module: mux4_sync

Interface
REQ-001 Parameter: WIDTH, default 2, data bit width of every data input and output; legal range 1..64.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled only on rising clk.
REQ-004 sel  input  2  select: 00->a, 01->b, 10->c, 11->d.
REQ-005 a  input  WIDTH  data input 0.
REQ-006 b  input  WIDTH  data input 1.
REQ-007 c  input  WIDTH  data input 2.
REQ-008 d  input  WIDTH  data input 3.
REQ-009 in_valid  input  1  qualifies sel/a..d for the registered path.
REQ-010 f  output  WIDTH  combinational selected data.
REQ-011 f_q  output  WIDTH  registered selected data.
REQ-012 f_q_valid  output  1  f_q holds a value captured from a valid cycle.
REQ-013 sel_q  output  2  select value captured alongside f_q.

Function
REQ-014 f SHALL equal the input chosen by sel per REQ-004 in the same cycle, zero latency, no clock or reset dependence.
REQ-015 f SHALL be fully combinational with no latches; every sel value SHALL drive f to a defined input.
REQ-016 On rising clk with rst=0 and in_valid=1: f_q<=f, sel_q<=sel, f_q_valid<=1; latency exactly one cycle.
REQ-017 On rising clk with rst=0 and in_valid=0: f_q_valid<=0; f_q and sel_q follow REQ-024/REQ-025.
REQ-018 Inputs a..d, sel and in_valid SHALL be sampled only at the rising clk; mid-cycle glitches SHALL affect f only.
REQ-019 Data SHALL pass unmodified: no sign extension, truncation or arithmetic at any WIDTH.
REQ-020 Back-to-back valid cycles SHALL each update f_q; no bubble and no backpressure.

Reset
REQ-021 With rst=1 at a rising clk: f_q<=0, sel_q<=2'b00, f_q_valid<=0, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous in_valid=1; that cycle's data SHALL be discarded.
REQ-023 rst SHALL NOT affect f; f keeps tracking sel and a..d during reset.

Configuration
REQ-024 Macro MUX4_SYNC_HOLD_EN defined: on in_valid=0 cycles, f_q and sel_q SHALL hold their previous values.
REQ-025 Macro MUX4_SYNC_HOLD_EN undefined: f_q<=f and sel_q<=sel on every non-reset rising clk, regardless of in_valid; f_q_valid still follows REQ-016/REQ-017.

Verification
REQ-026 WIDTH=2, a=0,b=1,c=2,d=3; sweep sel 00..11 -> f=0,1,2,3 in the same cycle.
REQ-027 WIDTH=8, sel=10, c=8'hA5, in_valid=1 for one cycle -> next cycle f_q=8'hA5, sel_q=10, f_q_valid=1; following idle cycle f_q_valid=0.
REQ-028 rst=1 and in_valid=1 on the same edge with d=8'hFF, sel=11 -> f_q=0, sel_q=00, f_q_valid=0; f=8'hFF throughout.
REQ-029 HOLD_EN defined: capture b=8'h3C (sel=01, valid), then sel=00, a=8'h11, in_valid=0 -> f_q stays 8'h3C; without the macro -> f_q=8'h11, f_q_valid=0.
REQ-030 WIDTH=1 and WIDTH=64: random sel and a..d for 1000 cycles with random in_valid -> f and f_q match a reference model every cycle.
